mem_stage: RTL

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mips_pkg.sv | 25 ++
 rtl/mem_stage_if.sv | 29 ++
 rtl/reg32.sv | 25 ++
 rtl/mem_stage.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline slice around the memory stage.
// Contents:
//   mem_state_t   - memory-stage FSM state (IDLE, ACCESS)
//   DATA_W        - datapath width
//   MEM_TIMEOUT   - ACCESS cycles allowed before the request is abandoned
//   ERR_MISALIGN  - err bit index: misaligned access attempted
//   ERR_TIMEOUT   - err bit index: memory never acknowledged
//   is_aligned()  - word-alignment test on the two address LSBs
package mips_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } mem_state_t;

  localparam int          DATA_W       = 32;
  localparam int unsigned MEM_TIMEOUT  = 255;
  localparam int          ERR_MISALIGN = 0;
  localparam int          ERR_TIMEOUT  = 1;

  function automatic logic is_aligned(input logic [1:0] addr_lsb);
    return addr_lsb == 2'b00;
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory request/acknowledge bus between the memory stage and the
// data memory.
//   req    master->slave  request, held until ack
//   we     master->slave  1=write, 0=read
//   addr   master->slave  word address
//   wdata  master->slave  store data
//   ack    slave->master  single-cycle completion pulse
//   rdata  slave->master  read data, valid while ack=1
interface mem_stage_if;
  import mips_pkg::*;

  logic              req;
  logic              we;
  logic [DATA_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ack;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, we, addr, wdata,
    input  ack, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output ack, rdata
  );

endinterface

// File: rtl/reg32.sv
// 32-bit data register with synchronous active-high reset and load enable.
//   clk  in   clock
//   rst  in   synchronous reset, clears q
//   en   in   load d into q on the rising edge
//   d    in   data in
//   q    out  registered data
module reg32 #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// MIPS memory stage with a request/ack data-memory port and the MEM/WB
// pipeline register.
//   clk, rst                    clock, synchronous active-high reset
//   MemRead_in .. zero_in       EX/MEM control bits and ALU zero flag
//   wn_in, alu_in, rd2_in       destination reg, ALU result/address, store data
//   dmem                        data-memory bus (master side)
//   stall                       freeze EX/MEM and earlier stages
//   PCSrc                       branch taken (never masked by stall)
//   RegWrite_out .. alu_out     MEM/WB register outputs
//   err                         sticky flags: [0] misaligned, [1] timeout
module mem_stage
  import mips_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              MemRead_in,
  input  logic              MemWrite_in,
  input  logic              Branch_in,
  input  logic              RegWrite_in,
  input  logic              MemtoReg_in,
  input  logic              zero_in,
  input  logic [4:0]        wn_in,
  input  logic [DATA_W-1:0] alu_in,
  input  logic [DATA_W-1:0] rd2_in,
  mem_stage_if.master       dmem,
  output logic              stall,
  output logic              PCSrc,
  output logic              RegWrite_out,
  output logic              MemtoReg_out,
  output logic [4:0]        wn_out,
  output logic [DATA_W-1:0] rdata_out,
  output logic [DATA_W-1:0] alu_out,
  output logic [1:0]        err
);

  // The counter holds the number of un-acked ACCESS cycles already spent, so
  // the cycle that finds it at MEM_TIMEOUT-1 is the last one allowed: the
  // request is then held for exactly MEM_TIMEOUT cycles.
  localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

  mem_state_t        state, state_nx;
  logic [7:0]        cnt;
  logic              we_r;
  logic [DATA_W-1:0] addr_r;
  logic [DATA_W-1:0] wdata_r;
  logic [1:0]        err_r;

  logic mem_op;
  logic aligned;
  logic start;
  logic misalign;
  logic tmo;
  logic capture;
  logic rd_load;

  // A write takes precedence when both read and write are asserted, which
  // falls out of using MemWrite_in alone as the direction bit.
  assign mem_op  = MemRead_in | MemWrite_in;
  assign aligned = is_aligned(alu_in[1:0]);
  assign PCSrc   = Branch_in & zero_in;

  assign dmem.req   = (state == ACCESS);
  assign dmem.we    = we_r;
  assign dmem.addr  = addr_r;
  assign dmem.wdata = wdata_r;
  assign err        = err_r;

  // ---- Stage decode: next state, stall and MEM/WB load controls ----
  always_comb begin
    state_nx = state;
    start    = 1'b0;
    misalign = 1'b0;
    tmo      = 1'b0;
    capture  = 1'b0;
    rd_load  = 1'b0;
    stall    = 1'b0;
    case (state)
      IDLE: begin
        if (!mem_op) begin
          capture = 1'b1;
        end else if (aligned) begin
          start    = 1'b1;
          stall    = 1'b1;
          state_nx = ACCESS;
        end else begin
          misalign = 1'b1;
        end
      end
      ACCESS: begin
        // ack is checked first so a completion on the final allowed cycle
        // is honoured rather than reported as a timeout.
        if (dmem.ack) begin
          capture  = 1'b1;
          rd_load  = ~we_r;
          state_nx = IDLE;
        end else if (cnt == TMO_LAST) begin
          tmo      = 1'b1;
          state_nx = IDLE;
        end else begin
          stall = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // ---- FSM, timeout counter, request registers and error flags ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= 8'd0;
      we_r    <= 1'b0;
      addr_r  <= '0;
      wdata_r <= '0;
      err_r   <= 2'b00;
    end else begin
      state <= state_nx;
      if (start) begin
        we_r    <= MemWrite_in;
        addr_r  <= alu_in;
        wdata_r <= rd2_in;
        cnt     <= 8'd0;
      end else if (state == ACCESS && !dmem.ack && !tmo) begin
        cnt <= cnt + 8'd1;
      end
      if (misalign) begin
        err_r[ERR_MISALIGN] <= 1'b1;
      end
      if (tmo) begin
        err_r[ERR_TIMEOUT] <= 1'b1;
      end
    end
  end

  // ---- MEM/WB control: capture on completion, otherwise a bubble ----
  always_ff @(posedge clk) begin
    if (rst) begin
      RegWrite_out <= 1'b0;
      MemtoReg_out <= 1'b0;
      wn_out       <= 5'd0;
    end else if (capture) begin
      RegWrite_out <= RegWrite_in;
      MemtoReg_out <= MemtoReg_in;
      wn_out       <= wn_in;
    end else begin
      RegWrite_out <= 1'b0;
      MemtoReg_out <= 1'b0;
      wn_out       <= 5'd0;
    end
  end

  // ---- MEM/WB data: bubbles leave both registers holding ----
  reg32 #(.DATA_W(DATA_W)) u_alu_reg (
    .clk (clk),
    .rst (rst),
    .en  (capture),
    .d   (alu_in),
    .q   (alu_out)
  );

  reg32 #(.DATA_W(DATA_W)) u_rdata_reg (
    .clk (clk),
    .rst (rst),
    .en  (rd_load),
    .d   (dmem.rdata),
    .q   (rdata_out)
  );

endmodule
